pwm_peripheral: RTL and testbench

Generates the 16 chip outputs from the register file written by the SPI peripheral. Each output is forced low, forced high, or driven by a shared 8-bit PWM waveform, according to the enable registers. The block sits directly downstream of the SPI register block and drives the user output pins. It runs on the system clock with a fixed prescaler. Duty-cycle changes are shadowed so that every PWM period is glitch-free.

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/pwm_timebase.sv | 66 ++++++
 rtl/pwm_peripheral.sv | 72 +++++++
 tb/tb_pwm_peripheral.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output block: step count, full-duty code,
// default prescaler and the per-pin output mode decode.
package pwm_pkg;

  localparam int         PWM_STEPS       = 256;
  localparam logic [7:0] DUTY_FULL       = 8'hFF;
  localparam int         CLK_DIV_DEFAULT = 13;

  typedef enum logic [1:0] {
    OFF         = 2'd0,
    STATIC_HIGH = 2'd1,
    PWM         = 2'd2
  } out_mode_t;

  // A disabled pin is off whatever its PWM select says.
  function automatic out_mode_t out_mode(input logic en_out, input logic en_pwm);
    if (!en_out) begin
      return OFF;
    end
    if (!en_pwm) begin
      return STATIC_HIGH;
    end
    return PWM;
  endfunction

  // Full-scale duty is a true 100 %; a plain compare would leave step 255 low.
  function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, 8-bit step counter and period-boundary duty shadow shared by all
// PWM pins. period_start is delayed one clk so it lines up with the registered
// pin outputs in the top level.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pwm_duty_cycle,
  output logic       tick,
  output logic [7:0] pwm_cnt,
  output logic [7:0] duty_q,
  output logic       period_start
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("pwm_timebase: CLK_DIV must be within 2..255");
  end

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       boundary;

  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (pwm_cnt == 8'hFF);

  // Prescaler: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Step counter wraps 255 -> 0 on its own; duty is sampled only at that wrap
  // so the compare never sees a new duty part way through a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (boundary) begin
        duty_q <= pwm_duty_cycle;
      end
    end
  end

  // Flag the first clk of step 0, registered to match the pin output latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= (pwm_cnt == 8'd0) && (div_cnt == 8'd0);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives the 16 user pins from the SPI-written enable registers: each pin is
// forced low, forced high, or follows the shared PWM level. Enables act on the
// next clk; only the duty cycle is shadowed.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_d;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_q;
  logic        tick;
  logic        pwm_lvl;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwm_duty_cycle (pwm_duty_cycle),
    .tick           (tick),
    .pwm_cnt        (pwm_cnt),
    .duty_q         (duty_q),
    .period_start   (period_start)
  );

  assign pwm_lvl = pwm_level(pwm_cnt, duty_q);

  // Per-pin output select.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < 16; i++) begin
      case (out_mode(en_out[i], en_pwm[i]))
        OFF:         out_d[i] = 1'b0;
        STATIC_HIGH: out_d[i] = 1'b1;
        PWM:         out_d[i] = pwm_lvl;
        default:     out_d[i] = 1'b0;
      endcase
    end
  end

  // Pin register; async reset pulls all pins low without waiting for a clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_d;
    end
  end

  // The step counter may only move on a prescaler tick.
  a_step_only_on_tick: assert property (
    @(posedge clk) disable iff (!rst_n) !tick |=> $stable(pwm_cnt)
  );

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: a per-clk scoreboard of expected {period_start,out}
// derived from clks elapsed since reset release, plus scenario tasks that
// measure high time and period length.
module tb_pwm_peripheral;
  import pwm_pkg::*;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty   = '0;
  logic [15:0] out;
  logic        period_start;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          s     = 0;
  logic [7:0]  cur_duty = '0;
  logic [16:0] sb_q[$];

  // One clk: push the expectation for the coming edge, advance, then compare.
  task automatic run_cycle();
    int          stp;
    logic        lvl;
    logic [15:0] e_out;
    logic [16:0] exp_v;
    logic [16:0] got_v;
    stp = (s / CLK_DIV) % 256;
    lvl = (cur_duty == 8'hFF) || (stp < int'(cur_duty));
    for (int i = 0; i < 16; i++) begin
      case (out_mode(en_out[i], en_pwm[i]))
        STATIC_HIGH: e_out[i] = 1'b1;
        PWM:         e_out[i] = lvl;
        default:     e_out[i] = 1'b0;
      endcase
    end
    sb_q.push_back({(s % PERIOD) == 0, e_out});
    if ((s % PERIOD) == PERIOD - 1) cur_duty = duty;
    s++;
    @(posedge clk);
    #2;
    exp_v = sb_q.pop_front();
    got_v = {period_start, out};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      if (bad <= 20)
        $display("FAIL scoreboard clk=%0d: got ps=%b out=%h, want ps=%b out=%h",
                 s, got_v[16], got_v[15:0], exp_v[16], exp_v[15:0]);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    s        = 0;
    cur_duty = '0;
  endtask

  // Run from the next period_start to the one after, counting clks where out[b] is high.
  task automatic measure_period(input int b, output int high, output int len);
    int guard;
    guard = 0;
    high  = 0;
    len   = 0;
    while (period_start !== 1'b1 && guard < PERIOD + 8) begin
      run_cycle();
      guard++;
    end
    do begin
      if (out[b] === 1'b1) high++;
      len++;
      run_cycle();
    end while (period_start !== 1'b1 && len < PERIOD + 8);
  endtask

  task automatic test_reset();
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty   = 8'h55;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got out=%h ps=%b, want out=0000 ps=0", out, period_start);
    end
    apply_reset();
    run_cycle();
  endtask

  task automatic test_static();
    apply_reset();
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty   = 8'h80;
    total++;
    if (out !== 16'h0000) begin
      bad++;
      $display("FAIL static_latency: got out=%h before any clk, want 0000", out);
    end
    run_cycle();
    total++;
    if (out !== 16'hFFFF) begin
      bad++;
      $display("FAIL static_first: got out=%h, want ffff", out);
    end
    for (int i = 0; i < 30; i++) begin
      run_cycle();
      total++;
      if (out !== 16'hFFFF) begin
        bad++;
        $display("FAIL static_hold: got out=%h at clk %0d, want ffff", out, i);
      end
    end
  endtask

  task automatic test_pwm50();
    int hi;
    int len;
    apply_reset();
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    measure_period(0, hi, len);
    total++;
    if (hi !== 0 || len !== PERIOD) begin
      bad++;
      $display("FAIL pwm50_first_period: got high=%0d len=%0d, want high=0 len=%0d", hi, len, PERIOD);
    end
    for (int p = 0; p < 2; p++) begin
      measure_period(0, hi, len);
      total++;
      if (hi !== 1664 || len !== PERIOD) begin
        bad++;
        $display("FAIL pwm50_period%0d: got high=%0d len=%0d, want high=1664 len=%0d", p, hi, len, PERIOD);
      end
    end
    total++;
    if (out[15:1] !== 15'd0) begin
      bad++;
      $display("FAIL pwm50_others: got out[15:1]=%h, want 0", out[15:1]);
    end
  endtask

  task automatic test_extremes();
    int hi;
    int len;
    apply_reset();
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h00;
    for (int p = 0; p < 3; p++) begin
      measure_period(0, hi, len);
      total++;
      if (hi !== 0 || len !== PERIOD) begin
        bad++;
        $display("FAIL duty00_period%0d: got high=%0d len=%0d, want high=0 len=%0d", p, hi, len, PERIOD);
      end
    end
    duty = 8'hFF;
    measure_period(0, hi, len);
    total++;
    if (hi !== 0) begin
      bad++;
      $display("FAIL dutyff_shadowed: got high=%0d in period with old duty, want 0", hi);
    end
    for (int p = 0; p < 2; p++) begin
      measure_period(0, hi, len);
      total++;
      if (hi !== PERIOD || len !== PERIOD) begin
        bad++;
        $display("FAIL dutyff_period%0d: got high=%0d len=%0d, want high=%0d len=%0d", p, hi, len, PERIOD, PERIOD);
      end
    end
  endtask

  // Runs straight after test_extremes, so the shadowed duty is already 0xFF.
  task automatic test_gating();
    en_out = 16'h0000;
    en_pwm = 16'hFFFF;
    duty   = 8'hFF;
    run_cycle();
    total++;
    if (out !== 16'h0000) begin
      bad++;
      $display("FAIL gating_off: got out=%h, want 0000", out);
    end
    en_out = 16'hFF00;
    total++;
    if (out !== 16'h0000) begin
      bad++;
      $display("FAIL gating_latency: got out=%h before clk, want 0000", out);
    end
    run_cycle();
    total++;
    if (out !== 16'hFF00) begin
      bad++;
      $display("FAIL gating_on: got out=%h, want ff00", out);
    end
  endtask

  task automatic test_shadow();
    int hi;
    int len;
    apply_reset();
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h40;
    measure_period(0, hi, len);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == 100 * CLK_DIV) duty = 8'hC0;
      if (out[0] === 1'b1) hi++;
      run_cycle();
    end
    total++;
    if (hi !== 832) begin
      bad++;
      $display("FAIL shadow_old_period: got high=%0d, want 832", hi);
    end
    total++;
    if (period_start !== 1'b1) begin
      bad++;
      $display("FAIL shadow_period_start: got ps=%b after %0d clks, want 1", period_start, PERIOD);
    end
    measure_period(0, hi, len);
    total++;
    if (hi !== 2496 || len !== PERIOD) begin
      bad++;
      $display("FAIL shadow_new_period: got high=%0d len=%0d, want high=2496 len=%0d", hi, len, PERIOD);
    end
  endtask

  task automatic test_reset_mid();
    int hi;
    int len;
    apply_reset();
    en_out = 16'h00FF;
    en_pwm = 16'h00F0;
    duty   = 8'h80;
    measure_period(4, hi, len);
    for (int i = 0; i < 50 * CLK_DIV; i++) run_cycle();
    total++;
    if (out !== 16'h00FF) begin
      bad++;
      $display("FAIL midreset_before: got out=%h at step 50, want 00ff", out);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: got out=%h ps=%b without clk, want 0000 0", out, period_start);
    end
    apply_reset();
    measure_period(4, hi, len);
    total++;
    if (hi !== 0 || len !== PERIOD) begin
      bad++;
      $display("FAIL midreset_first_period: got high=%0d len=%0d, want high=0 len=%0d", hi, len, PERIOD);
    end
    measure_period(4, hi, len);
    total++;
    if (hi !== 1664 || len !== PERIOD) begin
      bad++;
      $display("FAIL midreset_second_period: got high=%0d len=%0d, want high=1664 len=%0d", hi, len, PERIOD);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_pwm50();
    test_extremes();
    test_gating();
    test_shadow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
